jtroc_sndcmd: RTL

//  Main-to-sound command mailbox and interrupt scheduler for the Roc'n Rope sound board.
//  The main CPU side pushes 8-bit commands into a small FIFO. The head entry drives the
//  PSG0 port A input (cmd). Sound Z80 reads of port A pop the FIFO.
//  The block generates the Z80 int_n line, clears it on interrupt acknowledge, and

---
 rtl/jtroc_sndcmd.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/jtroc_sndcmd.sv
// Main-to-sound command mailbox for the Roc'n Rope sound board: a small command FIFO
// feeding PSG0 port A, plus the sound Z80 interrupt scheduler with an ack watchdog.
module jtroc_sndcmd #(
  parameter int AW       = 2,
  parameter int IRQ_MODE = 0,
  parameter int IRQ_TO   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       m2s_on,
  input  logic       snd_rd,
  input  logic       irq_ack,
  output logic [7:0] cmd,
  output logic       int_n,
  output logic       empty,
  output logic       full,
  output logic       ovf,
  output logic       irq_lost
);

  localparam int DEPTH = 2 ** AW;
  localparam int WW    = (IRQ_TO > 2) ? $clog2(IRQ_TO) : 1;
  localparam int TO_M1_I = (IRQ_TO > 0) ? (IRQ_TO - 1) : 0;
  localparam logic [WW-1:0] TO_M1  = WW'(TO_M1_I);
  localparam logic [WW-1:0] WD_ONE = WW'(1);
  localparam bit WD_EN = (IRQ_TO > 0);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [0:0] {
    IRQ_IDLE   = 1'b0,
    IRQ_ASSERT = 1'b1
  } irq_state_t;

  logic [7:0]    mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
  logic [7:0]    cmd_r, cmd_s;
  logic          empty_r, full_r, empty_s, full_s;
  logic          ovf_r, irq_lost_r, int_n_r;
  logic          push_s, pop_s, req_s, lost_s;
  logic          m2s_last_r;
  logic [WW-1:0] wd_r, wd_s;
  irq_state_t    state_r, state_s;

  // A pop frees a slot in the same cycle, so a push to a full FIFO still lands
  assign pop_s  = snd_rd & ~empty_r;
  assign push_s = main_wr & (~full_r | pop_s);

  // Next pointers, flags and head byte
  always_comb begin
    wr_ptr_s = wr_ptr_r;
    rd_ptr_s = rd_ptr_r;
    cmd_s    = cmd_r;
    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    empty_s = (rd_ptr_s == wr_ptr_s);
    full_s  = (rd_ptr_s[AW] != wr_ptr_s[AW]) && (rd_ptr_s[AW-1:0] == wr_ptr_s[AW-1:0]);
    // The new head may be the byte being written this very cycle
    if (pop_s) begin
      if (empty_s) begin
        cmd_s = cmd_r;
      end else if (push_s && (rd_ptr_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
        cmd_s = main_din;
      end else begin
        cmd_s = mem_r[rd_ptr_s[AW-1:0]];
      end
    end else if (push_s && empty_r) begin
      cmd_s = main_din;
    end else begin
      cmd_s = cmd_r;
    end
  end

  // Interrupt request source
  always_comb begin
    req_s = 1'b0;
    if (IRQ_MODE == 0) begin
      req_s = m2s_on & ~m2s_last_r;
    end else begin
      req_s = (push_s & empty_r) | (pop_s & ~empty_s);
    end
  end

  // IRQ state machine: a new request always wins over ack and the watchdog
  always_comb begin
    state_s = state_r;
    wd_s    = wd_r;
    lost_s  = 1'b0;
    case (state_r)
      IRQ_IDLE: begin
        wd_s = {WW{1'b0}};
        if (req_s) begin
          state_s = IRQ_ASSERT;
        end else begin
          state_s = IRQ_IDLE;
        end
      end
      IRQ_ASSERT: begin
        if (req_s) begin
          state_s = IRQ_ASSERT;
          wd_s    = {WW{1'b0}};
        end else if (irq_ack) begin
          state_s = IRQ_IDLE;
          wd_s    = {WW{1'b0}};
        end else if (cen && WD_EN) begin
          if (wd_r == TO_M1) begin
            state_s = IRQ_IDLE;
            wd_s    = {WW{1'b0}};
            lost_s  = 1'b1;
          end else begin
            wd_s = wd_r + WD_ONE;
          end
        end else begin
          state_s = IRQ_ASSERT;
        end
      end
      default: begin
        state_s = IRQ_IDLE;
        wd_s    = {WW{1'b0}};
      end
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
      cmd_r    <= 8'h00;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= main_din;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      cmd_r    <= cmd_s;
      empty_r  <= empty_s;
      full_r   <= full_s;
      ovf_r    <= ovf_r | (main_wr & ~push_s);
    end
  end

  // IRQ state, watchdog and sticky loss flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IRQ_IDLE;
      wd_r       <= {WW{1'b0}};
      int_n_r    <= 1'b1;
      irq_lost_r <= 1'b0;
      m2s_last_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      wd_r       <= wd_s;
      int_n_r    <= (state_s != IRQ_ASSERT);
      irq_lost_r <= irq_lost_r | lost_s;
      m2s_last_r <= m2s_on;
    end
  end

  assign cmd      = cmd_r;
  assign int_n    = int_n_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign ovf      = ovf_r;
  assign irq_lost = irq_lost_r;

endmodule
